// File: rtl/pbch_demap_ctrl.sv
// PBCH demapper sequencer: frames one SSB of PBCH data REs toward the QPSK demapper
// and tracks returned LLR strobes. Define DEMAP_CTRL_TIMEOUT_EN to add a watchdog.
module pbch_demap_ctrl #(
  parameter int unsigned IQ_DW          = 16,
  parameter int unsigned LLR_DW         = 8,
  parameter int unsigned NUM_RE         = 432,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ssb_start_i,
  input  logic [2*IQ_DW-1:0] s_axis_in_tdata,
  input  logic [1:0]         s_axis_in_tuser,
  input  logic               s_axis_in_tvalid,
  output logic [2*IQ_DW-1:0] m_axis_out_tdata,
  output logic [1:0]         m_axis_out_tuser,
  output logic               m_axis_out_tlast,
  output logic               m_axis_out_tvalid,
  input  logic               llr_tvalid_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic [9:0]         re_cnt_o
);
  localparam int unsigned NUM_LLR   = 2 * NUM_RE;
  localparam int unsigned LLR_CNT_W = $clog2(NUM_LLR + 1);
  localparam logic [1:0]  RE_PBCH_DATA = 2'd1;

  // Only LLR strobes are observed, so LLR_DW is carried for interface compatibility;
  // an unusable parameter set shows up as this named block in the elaborated design.
  if (NUM_RE == 0 || NUM_RE > 1023 || LLR_DW == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LLR_CNT_W-1:0]   llr_cnt_q, llr_cnt_d;
  logic [9:0]             re_cnt_d;
  logic [2*IQ_DW-1:0]     tdata_d;
  logic [1:0]             tuser_d;
  logic                   tlast_d, tvalid_d, done_d, error_d, busy_d;

`ifdef DEMAP_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, counters and next output values; start always wins over completion.
  always_comb begin
    state_d   = state_q;
    re_cnt_d  = re_cnt_o;
    llr_cnt_d = llr_cnt_q;
    tdata_d   = '0;
    tuser_d   = 2'd0;
    tlast_d   = 1'b0;
    tvalid_d  = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
`ifdef DEMAP_CTRL_TIMEOUT_EN
    wd_cnt_d  = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (ssb_start_i) begin
          state_d   = COLLECT;
          re_cnt_d  = '0;
          llr_cnt_d = '0;
        end
      end
      COLLECT, DRAIN: begin
        if (ssb_start_i) begin
          error_d   = 1'b1;
          state_d   = COLLECT;
          re_cnt_d  = '0;
          llr_cnt_d = '0;
        end else begin
`ifdef DEMAP_CTRL_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
          if (llr_tvalid_i && llr_cnt_q != LLR_CNT_W'(NUM_LLR))
            llr_cnt_d = llr_cnt_q + LLR_CNT_W'(1);
          if (state_q == COLLECT && s_axis_in_tvalid && s_axis_in_tuser == RE_PBCH_DATA) begin
            re_cnt_d = re_cnt_o + 10'd1;
            tvalid_d = 1'b1;
            tuser_d  = RE_PBCH_DATA;
            tdata_d  = s_axis_in_tdata;
            if (re_cnt_d == 10'(NUM_RE)) begin
              tlast_d = 1'b1;
              state_d = DRAIN;
            end
          end
          if (state_q == DRAIN && llr_cnt_d == LLR_CNT_W'(NUM_LLR)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
`ifdef DEMAP_CTRL_TIMEOUT_EN
          else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      llr_cnt_q         <= '0;
      re_cnt_o          <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= 2'd0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      llr_cnt_q         <= llr_cnt_d;
      re_cnt_o          <= re_cnt_d;
      m_axis_out_tdata  <= tdata_d;
      m_axis_out_tuser  <= tuser_d;
      m_axis_out_tlast  <= tlast_d;
      m_axis_out_tvalid <= tvalid_d;
      busy_o            <= busy_d;
      done_o            <= done_d;
      error_o           <= error_d;
    end
  end

`ifdef DEMAP_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end
`endif

endmodule
